tmds_encoder: RTL and testbench
===============================

// Module: tmds_encoder
// PURPOSE
// - DVI/HDMI TMDS 8b/10b encoder for one colour channel, pixel-clock domain.
// - Converts pixel byte plus control bits into a DC-balanced, transition-minimised 10-bit symbol.
// - Sits directly upstream of the 10-bit serializer; one instance per channel (B/G/R).
// - tmds[0] is the first bit on the wire.
// PARAMETERS
// - DISP_W  5  Running-disparity counter width in bits, two's complement; legal >= 5.
// PORTS
// - clk         in   1       Pixel clock; all state updates on rising edge.
// - rst         in   1       Asynchronous reset, active-low: asserted at 0, released synchronously to clk.
// - de          in   1       Data enable: 1 = active video, 0 = control/blanking period.
// - d           in   8       Pixel byte; sampled only when de=1.
// - c           in   2       Control bits {c1,c0} (HSYNC/VSYNC on ch0); sampled only when de=0.
// - tmds        out  10      Encoded symbol, registered; feeds the serializer data input.
// - disparity   out  DISP_W  Running disparity after the symbol on tmds; signed, debug only.
// BEHAVIOUR
// - Reset (rst=0): tmds=10'b1101010100 (control code for c=00), disparity=0, all pipeline registers cleared.
// - Reset mid-stream: discards both pipeline stages.
// - Latency: exactly 2 clk. tmds at edge N+2 encodes {de,d,c} sampled at edge N.
// - Throughput: one symbol per clk, no stalls, no handshake.
// - Stage 1, registered, when de=1:
//   - n1 = popcount(d).
//   - If n1>4, or n1==4 and d[0]==0: XNOR path, q_m[8]=0. Otherwise: XOR path, q_m[8]=1.
//   - q_m[0]=d[0]; q_m[i] = q_m[i-1] XOR/XNOR d[i], for i=1..7.
//   - de and c are delayed alongside q_m.
// - Stage 2, when de=1: n1q = popcount(q_m[7:0]); n0q = 8-n1q; cnt = current disparity.
//   - Case A, cnt==0 or n1q==n0q:
//     - tmds = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
//     - cnt += q_m[8] ? (n1q-n0q) : (n0q-n1q).
//   - Case B, (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q):
//     - tmds = {1, q_m[8], ~q_m[7:0]}.
//     - cnt += 2*q_m[8] + (n0q-n1q).
//   - Case C, otherwise:
//     - tmds = {0, q_m[8], q_m[7:0]}.
//     - cnt += -2*(~q_m[8]) + (n1q-n0q).
// - Stage 2, when de=0: cnt=0, and tmds is set from c:
//   - c=00 -> 1101010100
//   - c=01 -> 0010101011
//   - c=10 -> 0101010100
//   - c=11 -> 1010101011
// - de transitions: 1->0 and 0->1 take effect on the symbol-exact cycle. The first active pixel after blanking always starts at cnt=0.
// - Arithmetic: all disparity math is signed DISP_W bits. Legal range is -8..+8, so no saturation is needed and no overflow can occur for DISP_W>=5.
// - The d value is ignored when de=0. The c value is ignored when de=1.
// CONFIGURATION
// - Macro TMDS_ENC_TERC4_EN. When defined, adds two input ports:
//   - isl  in  1: data-island period.
//   - aux  in  4: island nibble.
//   - isl is delayed through the pipeline like de; de=1 has priority over isl.
//   - With de=0 and isl=1: tmds = HDMI TERC4(aux), cnt=0.
//   - TERC4 examples: aux 0x0 -> 1010011100, 0x5 -> 0100011110, 0xF -> 1011000011. The full 16-entry HDMI 1.3 table is required.
// - When not defined: no isl/aux ports; pure DVI encoder.
// TESTING
// - Reset: rst=0 -> tmds=0x354, disparity=0; rst=1 then de=0,c=00 -> tmds stays 0x354.
// - Balance: de=1, d=0x00 for 3 clk from cnt=0:
//   - tmds = 0x100, 0x3FF, 0x100.
//   - disparity = -8, +2, -6.
//   - Each output is 2 clk after its input.
// - XNOR path: de=1, d=0xFF from cnt=0 -> tmds=0x200, disparity=-8.
// - Control codes: de=0, c sweeps 00,01,10,11 -> tmds = 0x354, 0x0AB, 0x154, 0x2AB. disparity=0 throughout.
// - Disparity reset: 5 active pixels d=0x00, then de=0 for 1 clk, then d=0x00 -> first active symbol after blanking is 0x100.
// - TERC4 (TMDS_ENC_TERC4_EN): de=0, isl=1, aux=0x5 -> tmds=0x11E. With de=1 and isl=1 -> the video encoding wins.

Source files
------------

// File: rtl/tmds_encoder.sv
// tmds_encoder: DVI/HDMI TMDS 8b/10b encoder for one colour channel.
// Stage 1 registers the transition-minimised word q_m.
// Stage 2 picks DC-balancing inversion, tracks running disparity and registers the symbol.
// Symbols are produced one per clk with no stalls.
// Optional feature: define TMDS_ENC_TERC4_EN to add HDMI data-island (TERC4) encoding
// through the extra isl/aux ports.
module tmds_encoder #(
  parameter int DISP_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     de,
  input  logic [7:0]               d,
  input  logic [1:0]               c,
`ifdef TMDS_ENC_TERC4_EN
  input  logic                     isl,
  input  logic [3:0]               aux,
`endif
  output logic [9:0]               tmds,
  output logic signed [DISP_W-1:0] disparity
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

`ifdef TMDS_ENC_TERC4_EN
  // HDMI 1.3 TERC4 code table, bit 0 is first on the wire
  function automatic logic [9:0] terc4(input logic [3:0] a);
    logic [9:0] s;
    case (a)
      4'h0: s = 10'b1010011100;
      4'h1: s = 10'b1001100011;
      4'h2: s = 10'b1011100100;
      4'h3: s = 10'b1011100010;
      4'h4: s = 10'b0101110001;
      4'h5: s = 10'b0100011110;
      4'h6: s = 10'b0110001110;
      4'h7: s = 10'b0100111100;
      4'h8: s = 10'b1011001100;
      4'h9: s = 10'b0100111001;
      4'hA: s = 10'b0110011100;
      4'hB: s = 10'b1011000110;
      4'hC: s = 10'b1010001110;
      4'hD: s = 10'b1001110001;
      4'hE: s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction
`endif

  // ---------------- stage 1 ----------------
  logic [3:0] n1;
  logic       xnor_sel;
  logic [8:0] qm_nxt;

  logic [8:0] qm1;
  logic       de1;
  logic [1:0] c1;
`ifdef TMDS_ENC_TERC4_EN
  logic       isl1;
  logic [3:0] aux1;
`endif

  // transition-minimising XOR/XNOR chain over the pixel byte
  always_comb begin
    n1        = popcnt8(d);
    xnor_sel  = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    qm_nxt    = '0;
    qm_nxt[0] = d[0];
    for (int i = 1; i < 8; i++)
      qm_nxt[i] = xnor_sel ? ~(qm_nxt[i-1] ^ d[i]) : (qm_nxt[i-1] ^ d[i]);
    qm_nxt[8] = ~xnor_sel;
  end

  // stage 1 register: q_m plus the delayed control qualifiers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qm1  <= '0;
      de1  <= 1'b0;
      c1   <= 2'b00;
`ifdef TMDS_ENC_TERC4_EN
      isl1 <= 1'b0;
      aux1 <= '0;
`endif
    end else begin
      qm1  <= qm_nxt;
      de1  <= de;
      c1   <= c;
`ifdef TMDS_ENC_TERC4_EN
      isl1 <= isl;
      aux1 <= aux;
`endif
    end
  end

  // ---------------- stage 2 ----------------
  // Disparity math is modular in DISP_W bits; sign is read from the MSB so no
  // signed casts are needed. All legal values lie in -8..+8.
  logic [DISP_W-1:0] cnt, cnt_nxt;
  logic [9:0]        tmds_nxt;
  logic [3:0]        n1q;
  logic [DISP_W-1:0] diff;     // n1q - n0q
  logic [DISP_W-1:0] two_qm8;  // 2*q_m[8]
  logic              cnt_zero, cnt_pos, cnt_neg;

  // DC-balance decision and next running disparity
  always_comb begin
    n1q      = popcnt8(qm1[7:0]);
    diff     = (DISP_W'(n1q) << 1) - DISP_W'(8);
    two_qm8  = qm1[8] ? DISP_W'(2) : '0;
    cnt_zero = (cnt == '0);
    cnt_neg  = cnt[DISP_W-1];
    cnt_pos  = !cnt_zero && !cnt_neg;
    tmds_nxt = CTRL_00;
    cnt_nxt  = '0;
    if (de1) begin
      if (cnt_zero || (n1q == 4'd4)) begin
        tmds_nxt = {~qm1[8], qm1[8], qm1[8] ? qm1[7:0] : ~qm1[7:0]};
        cnt_nxt  = qm1[8] ? (cnt + diff) : (cnt - diff);
      end else if ((cnt_pos && (n1q > 4'd4)) || (cnt_neg && (n1q < 4'd4))) begin
        tmds_nxt = {1'b1, qm1[8], ~qm1[7:0]};
        cnt_nxt  = cnt + two_qm8 - diff;
      end else begin
        tmds_nxt = {1'b0, qm1[8], qm1[7:0]};
        cnt_nxt  = cnt - (qm1[8] ? '0 : DISP_W'(2)) + diff;
      end
`ifdef TMDS_ENC_TERC4_EN
    end else if (isl1) begin
      tmds_nxt = terc4(aux1);
`endif
    end else begin
      case (c1)
        2'b00:   tmds_nxt = CTRL_00;
        2'b01:   tmds_nxt = CTRL_01;
        2'b10:   tmds_nxt = CTRL_10;
        default: tmds_nxt = CTRL_11;
      endcase
    end
  end

  // stage 2 register: output symbol and running disparity
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmds <= CTRL_00;
      cnt  <= '0;
    end else begin
      tmds <= tmds_nxt;
      cnt  <= cnt_nxt;
    end
  end

  assign disparity = cnt;

endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: directed vector table plus short hand-written sequences
// for reset, latency, blanking disparity reset and (optionally) TERC4.
module tb_tmds_encoder;

  localparam int DISP_W = 5;

  logic                     clk;
  logic                     rst;
  logic                     de;
  logic [7:0]               d;
  logic [1:0]               c;
`ifdef TMDS_ENC_TERC4_EN
  logic                     isl;
  logic [3:0]               aux;
`endif
  logic [9:0]               tmds;
  logic signed [DISP_W-1:0] disparity;

  int checks   = 0;
  int failures = 0;

  tmds_encoder #(.DISP_W(DISP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .de        (de),
    .d         (d),
    .c         (c),
`ifdef TMDS_ENC_TERC4_EN
    .isl       (isl),
    .aux       (aux),
`endif
    .tmds      (tmds),
    .disparity (disparity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       de;
    logic [7:0] d;
    logic [1:0] c;
    logic [9:0] exp_tmds;
    int         exp_disp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [9:0] exp_t, input int exp_dp);
    int act_dp;
    act_dp = int'(disparity);
    checks++;
    if (tmds !== exp_t) begin
      failures++;
      $display("FAIL %s tmds: got 0x%03h want 0x%03h", name, tmds, exp_t);
    end
    checks++;
    if (act_dp != exp_dp) begin
      failures++;
      $display("FAIL %s disparity: got %0d want %0d", name, act_dp, exp_dp);
    end
  endtask

  task automatic drive(input logic de_i, input logic [7:0] d_i, input logic [1:0] c_i);
    de = de_i;
    d  = d_i;
    c  = c_i;
  endtask

  function automatic vec_t mk(input logic de_i, input logic [7:0] d_i, input logic [1:0] c_i,
                              input logic [9:0] t, input int dp);
    vec_t v;
    v.de = de_i; v.d = d_i; v.c = c_i; v.exp_tmds = t; v.exp_disp = dp;
    return v;
  endfunction

  initial begin
    // expected symbols are the output two clocks after each row is applied
    vecs[0]  = mk(1'b0, 8'h00, 2'b00, 10'h354,  0);
    vecs[1]  = mk(1'b1, 8'h00, 2'b00, 10'h100, -8);  // balance run from cnt=0
    vecs[2]  = mk(1'b1, 8'h00, 2'b00, 10'h3FF,  2);
    vecs[3]  = mk(1'b1, 8'h00, 2'b00, 10'h100, -6);
    vecs[4]  = mk(1'b0, 8'h00, 2'b00, 10'h354,  0);
    vecs[5]  = mk(1'b1, 8'hFF, 2'b00, 10'h200, -8);  // XNOR path
    vecs[6]  = mk(1'b0, 8'hFF, 2'b01, 10'h0AB,  0);  // d ignored in blanking
    vecs[7]  = mk(1'b0, 8'hFF, 2'b10, 10'h154,  0);
    vecs[8]  = mk(1'b0, 8'hFF, 2'b11, 10'h2AB,  0);
    vecs[9]  = mk(1'b1, 8'h55, 2'b11, 10'h133,  0);  // c ignored, balanced q_m
    vecs[10] = mk(1'b1, 8'hAA, 2'b00, 10'h233,  0);  // n1==4, d0==0 -> XNOR
    vecs[11] = mk(1'b1, 8'h01, 2'b00, 10'h1FF,  8);  // reach +8
    vecs[12] = mk(1'b1, 8'h01, 2'b00, 10'h300,  2);  // case B, q_m8=1
    vecs[13] = mk(1'b1, 8'hFF, 2'b00, 10'h200, -6);  // case B, q_m8=0
    vecs[14] = mk(1'b1, 8'h00, 2'b00, 10'h3FF,  4);
    vecs[15] = mk(1'b0, 8'h00, 2'b00, 10'h354,  0);
    vecs[16] = mk(1'b1, 8'h00, 2'b00, 10'h100, -8);
    vecs[17] = mk(1'b1, 8'hFF, 2'b00, 10'h0FF, -2);  // case C, q_m8=0
    vecs[18] = mk(1'b1, 8'h55, 2'b00, 10'h133, -2);  // case A with cnt!=0
    vecs[19] = mk(1'b0, 8'h00, 2'b00, 10'h354,  0);

    drive(1'b0, 8'h00, 2'b00);
`ifdef TMDS_ENC_TERC4_EN
    isl = 1'b0;
    aux = 4'h0;
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", 10'h354, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", 10'h354, 0);

    // table sweep
    for (int i = 0; i < NV + 2; i++) begin
      @(negedge clk);
      if (i >= 2) chk($sformatf("vec%0d", i - 2), vecs[i-2].exp_tmds, vecs[i-2].exp_disp);
      if (i < NV) drive(vecs[i].de, vecs[i].d, vecs[i].c);
      else        drive(1'b0, 8'h00, 2'b00);
    end

    // latency: a lone pixel shows up after exactly two clocks
    @(negedge clk);
    drive(1'b1, 8'hFF, 2'b00);
    @(negedge clk);
    chk("latency_1clk", 10'h354, 0);
    drive(1'b0, 8'h00, 2'b00);
    @(negedge clk);
    chk("latency_2clk", 10'h200, -8);
    repeat (2) @(negedge clk);

    // blanking clears disparity: 5 pixels, 1 blank, 1 pixel
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 6) chk("dreset_px5", 10'h100, -4);
      if (i == 7) chk("dreset_blank", 10'h354, 0);
      if (i == 8) chk("dreset_first", 10'h100, -8);
      if (i < 5 || i == 6) drive(1'b1, 8'h00, 2'b00);
      else                 drive(1'b0, 8'h00, 2'b00);
    end
    repeat (2) @(negedge clk);

    // mid-stream reset: async clear, and the pixel held in stage 1 is dropped
    drive(1'b1, 8'h00, 2'b00);
    @(negedge clk);
    drive(1'b1, 8'hFF, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 8'h00, 2'b00);
    #1;
    chk("async_reset", 10'h354, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_flush", 10'h354, 0);

`ifdef TMDS_ENC_TERC4_EN
    @(negedge clk);
    isl = 1'b1;
    aux = 4'h5;
    repeat (2) @(negedge clk);
    chk("terc4_5", 10'h11E, 0);
    aux = 4'h0;
    repeat (2) @(negedge clk);
    chk("terc4_0", 10'h29C, 0);
    aux = 4'hF;
    repeat (2) @(negedge clk);
    chk("terc4_F", 10'h2C3, 0);
    drive(1'b1, 8'h00, 2'b00);
    repeat (2) @(negedge clk);
    chk("de_over_isl", 10'h100, -8);
    isl = 1'b0;
    drive(1'b0, 8'h00, 2'b00);
    repeat (2) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
